// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: turns one packed operand word per cycle into the diagonal
// wavefront a systolic array expects, then flushes, flags the last diagonal and pulses done.
module operand_skew_feeder #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_lane_valid,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_W = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LANES-1:0]  last_q;
  logic              acc_s;

  assign acc_s = in_valid && in_ready_q;

  // State, flush counter and status output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; FLUSH lasts LANES cycles so the deepest lane fully drains
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (acc_s) begin
          if (in_last) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(LANES - 1);
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs decoded from the next state so they register in step with it
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    case (state_d)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      ST_STREAM: begin
        in_ready_d = 1'b1;
      end
      ST_FLUSH: begin
        in_ready_d = 1'b0;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b1;
      end
    endcase
  end

  // Lane i is an (i+1)-deep delay line; non-accept cycles inject zero/invalid slots
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [i:0][DATA_W-1:0] data_q;
    logic [i:0]             vld_q;

    // Per-lane data/valid shift chain
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q <= '0;
        vld_q  <= '0;
      end else begin
        data_q[0] <= acc_s ? in_data[i*DATA_W +: DATA_W] : {DATA_W{1'b0}};
        vld_q[0]  <= acc_s;
        for (int s = 1; s <= i; s++) begin
          data_q[s] <= data_q[s-1];
          vld_q[s]  <= vld_q[s-1];
        end
      end
    end

    assign out_data[i*DATA_W +: DATA_W] = data_q[i];
    assign out_lane_valid[i]            = vld_q[i];
  end

  // Last marker rides alongside the deepest lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= '0;
    end else begin
      last_q <= {last_q[LANES-2:0], acc_s && in_last};
    end
  end

  assign out_last = last_q[LANES-1];
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder (LANES=4, DATA_W=8) using hand-computed cycle tables.
module tb_operand_skew_feeder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_lane_valid;
  logic        out_last;
  logic        busy;
  logic        done;

  int total;
  int bad;

  // Row k: inputs driven before edge k, outputs expected in the cycle after edge k
  logic        t_vin  [16];
  logic [31:0] t_din  [16];
  logic        t_lin  [16];
  logic [31:0] t_dout [16];
  logic [3:0]  t_vout [16];
  logic        t_last [16];
  logic        t_done [16];
  logic        t_rdy  [16];

  operand_skew_feeder #(.LANES(4), .DATA_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic row(input int k, input logic v, input logic [31:0] d, input logic l,
                     input logic [31:0] od, input logic [3:0] ov, input logic ol,
                     input logic odn, input logic ordy);
    t_vin[k]  = v;  t_din[k]  = d;  t_lin[k]  = l;
    t_dout[k] = od; t_vout[k] = ov; t_last[k] = ol;
    t_done[k] = odn; t_rdy[k] = ordy;
  endtask

  task automatic run_table(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = t_vin[k];
      in_data  = t_din[k];
      in_last  = t_lin[k];
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("%s.c%0d.data", name, k + 1), out_data, t_dout[k]);
      check_eq($sformatf("%s.c%0d.lvalid", name, k + 1), 32'(out_lane_valid), 32'(t_vout[k]));
      check_eq($sformatf("%s.c%0d.last", name, k + 1), 32'(out_last), 32'(t_last[k]));
      check_eq($sformatf("%s.c%0d.done", name, k + 1), 32'(done), 32'(t_done[k]));
      check_eq($sformatf("%s.c%0d.ready", name, k + 1), 32'(in_ready), 32'(t_rdy[k]));
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_last  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".data"}, out_data, 32'h0);
    check_eq({tag, ".lvalid"}, 32'(out_lane_valid), 32'h0);
    check_eq({tag, ".last"}, 32'(out_last), 32'h0);
    check_eq({tag, ".done"}, 32'(done), 32'h0);
    check_eq({tag, ".busy"}, 32'(busy), 32'h0);
    check_eq({tag, ".ready"}, 32'(in_ready), 32'h0);
  endtask

  task automatic load_four_word();
    row(0, 1'b1, 32'h13121110, 1'b0, 32'h00000010, 4'b0001, 1'b0, 1'b0, 1'b1);
    row(1, 1'b1, 32'h23222120, 1'b0, 32'h00001120, 4'b0011, 1'b0, 1'b0, 1'b1);
    row(2, 1'b1, 32'h33323130, 1'b0, 32'h00122130, 4'b0111, 1'b0, 1'b0, 1'b1);
    row(3, 1'b1, 32'h43424140, 1'b1, 32'h13223140, 4'b1111, 1'b0, 1'b0, 1'b0);
    row(4, 1'b0, 32'h0,        1'b0, 32'h23324100, 4'b1110, 1'b0, 1'b0, 1'b0);
    row(5, 1'b0, 32'h0,        1'b0, 32'h33420000, 4'b1100, 1'b0, 1'b0, 1'b0);
    row(6, 1'b0, 32'h0,        1'b0, 32'h43000000, 4'b1000, 1'b1, 1'b0, 1'b0);
    row(7, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b0);
    row(8, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_last  = 1'b0;

    // Reset behaviour, including an asynchronous assertion with stale inputs
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("rst.release.ready", 32'(in_ready), 32'h1);
    check_eq("rst.release.busy", 32'(busy), 32'h0);
    in_valid = 1'b1; in_data = 32'hAABBCCDD; in_last = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("rst.pre.data", out_data, 32'h000000DD);
    check_eq("rst.pre.busy", 32'(busy), 32'h1);
    in_data = 32'h55667788;
    #2 rst = 1'b0;
    #1 check_all_zero("rst.async");
    @(posedge clk); @(negedge clk);
    check_all_zero("rst.held");
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0;
    @(posedge clk); @(negedge clk);
    check_eq("rst.after.ready", 32'(in_ready), 32'h1);
    check_eq("rst.after.busy", 32'(busy), 32'h0);
    check_eq("rst.after.data", out_data, 32'h0);

    // Single-word stream
    row(0, 1'b1, 32'h44332211, 1'b1, 32'h00000011, 4'b0001, 1'b0, 1'b0, 1'b0);
    row(1, 1'b0, 32'h0, 1'b0, 32'h00002200, 4'b0010, 1'b0, 1'b0, 1'b0);
    row(2, 1'b0, 32'h0, 1'b0, 32'h00330000, 4'b0100, 1'b0, 1'b0, 1'b0);
    row(3, 1'b0, 32'h0, 1'b0, 32'h44000000, 4'b1000, 1'b1, 1'b0, 1'b0);
    row(4, 1'b0, 32'h0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b0);
    row(5, 1'b0, 32'h0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_table("single", 6);

    // Four back-to-back words
    load_four_word();
    run_table("b2b", 9);

    // Bubble between two words
    row(0, 1'b1, 32'h0D0C0B0A, 1'b0, 32'h0000000A, 4'b0001, 1'b0, 1'b0, 1'b1);
    row(1, 1'b0, 32'h0,        1'b0, 32'h00000B00, 4'b0010, 1'b0, 1'b0, 1'b1);
    row(2, 1'b1, 32'h1D1C1B1A, 1'b1, 32'h000C001A, 4'b0101, 1'b0, 1'b0, 1'b0);
    row(3, 1'b0, 32'h0,        1'b0, 32'h0D001B00, 4'b1010, 1'b0, 1'b0, 1'b0);
    row(4, 1'b0, 32'h0,        1'b0, 32'h001C0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    row(5, 1'b0, 32'h0,        1'b0, 32'h1D000000, 4'b1000, 1'b1, 1'b0, 1'b0);
    row(6, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b0);
    row(7, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_table("bubble", 8);

    // Words offered while not ready must be dropped, with a single done pulse
    row(0, 1'b1, 32'h44332211, 1'b1, 32'h00000011, 4'b0001, 1'b0, 1'b0, 1'b0);
    row(1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00002200, 4'b0010, 1'b0, 1'b0, 1'b0);
    row(2, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00330000, 4'b0100, 1'b0, 1'b0, 1'b0);
    row(3, 1'b1, 32'hDEADBEEF, 1'b1, 32'h44000000, 4'b1000, 1'b1, 1'b0, 1'b0);
    row(4, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b0);
    row(5, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
    row(6, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
    row(7, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_table("drop", 8);

    // Reset in the middle of a stream, then a clean stream afterwards
    load_four_word();
    run_table("midrst", 2);
    in_valid = 1'b1; in_data = 32'h33323130; in_last = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("midrst.async");
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check_all_zero("midrst.held");
    end
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0;
    @(posedge clk); @(negedge clk);
    check_eq("midrst.after.ready", 32'(in_ready), 32'h1);
    check_eq("midrst.after.busy", 32'(busy), 32'h0);
    check_eq("midrst.after.done", 32'(done), 32'h0);
    check_eq("midrst.after.data", out_data, 32'h0);
    load_four_word();
    run_table("restream", 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
# operand_skew_feeder

Upstream operand stage for the systolic TPU core. It accepts one packed operand word per cycle from a global buffer read port (activation or weight SRAM). Each lane i is delayed by i extra cycles, producing the diagonal wavefront the array expects; idle lanes are zero-filled. After the word flagged last, it flushes the skew pipeline, marks the final diagonal and pulses done, so the core controller knows the operand stream has fully entered the array.

## Interface
- LANES, 4, number of array rows/columns fed (lanes), ≥2
- DATA_W, 8, bits per lane element; word width = LANES*DATA_W (matches `WORD_SIZE` at defaults)
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data/in_last valid this cycle
- in_data  input  LANES*DATA_W  packed word; lane i = bits [i*DATA_W +: DATA_W]
- in_last  input  1  qualifies the final word of the stream; ignored unless in_valid
- in_ready  output  1  word accepted at clock edge when in_valid && in_ready
- out_data  output  LANES*DATA_W  skewed word to array edge; invalid lanes are 0
- out_lane_valid  output  LANES  per-lane valid, skewed identically to data
- out_last  output  1  high in the cycle lane LANES-1 carries the last word
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after the stream fully drained

## Operation
- Per-lane delay line: lane i is a chain of i+1 registers (data + valid); lane 0 has 1 register. All are registered outputs.
- Accept condition acc = in_valid && in_ready. On acc, lane i stage 0 loads in_data lane i with valid=1; otherwise it loads 0 with valid=0. No lane ever holds stale data.
- Last marker travels down a LANES-deep register chain alongside lane LANES-1; its output is out_last.
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE: in_ready=1. acc && !in_last → STREAM. acc && in_last → FLUSH (single-word stream).
  - STREAM: in_ready=1. acc && in_last → FLUSH. Bubbles (in_valid=0) stay in STREAM and inject zero/invalid slots.
  - FLUSH: in_ready=0; load flush counter with LANES-1 on entry and decrement each cycle; leave when counter=0 → DONE (exactly LANES cycles in FLUSH).
  - DONE: done=1 for one cycle → IDLE.
- in_valid while in_ready=0 is ignored and its data dropped. The upstream address generator must hold off.
- Reset values: in_ready=0 during reset, 1 after (IDLE); out_data=0; out_lane_valid=0; out_last=0; busy=0; done=0; all delay stages cleared; counter=0.
- Reset mid-stream: all pipeline contents discarded immediately (asynchronous), FSM to IDLE, no done pulse.

## Timing
- Word accepted at edge t: lane i visible on outputs from edge t+1+i until edge t+2+i.
- Sustained throughput: one word per cycle in IDLE/STREAM; no back-pressure from the array.
- Last word accepted at edge t:
  - out_last high from edge t+LANES for one cycle, coinciding with lane LANES-1 of that word.
  - FSM in FLUSH for edges t..t+LANES-1.
  - done high from edge t+LANES+1 for one cycle.
  - in_ready returns to 1 at edge t+LANES+2.
- Minimum gap between last-word accept and the next stream's first accept: LANES+2 cycles.

## Test plan
- Reset: assert rst=0 mid-cycle with stale inputs → all outputs 0 immediately; after release, in_ready=1, busy=0.
- Single word 0x44332211 with in_last at edge 0 (LANES=4):
  - lane0=0x11 at cycle 1, 0x22 on lane1 at cycle 2, 0x33 on lane2 at cycle 3, 0x44 on lane3 at cycle 4 with out_last=1.
  - Every other lane is 0/invalid.
  - done=1 at cycle 5; in_ready=1 at cycle 6.
- Four back-to-back words W0..W3 (W3 last):
  - cycle 4 shows W3.l0, W2.l1, W1.l2, W0.l3 with out_lane_valid=4'b1111.
  - out_last at cycle 7 together with W3.l3.
- Bubble: W0, idle cycle, W1(last) → W0.l0 at cycle 1, zero/invalid lane0 at cycle 2, W1.l0 at cycle 3; the bubble appears diagonally on lanes 1–3.
- Dropped input: drive in_valid=1 with 0xDEADBEEF during FLUSH → never appears on out_data; no second done pulse.
- Reset asserted at cycle 2 of a 4-word stream → outputs 0 at once, state IDLE, done never pulses; a new stream afterwards behaves exactly as in scenario 3.
